// File: rtl/wb_arbiter2_if.sv
// Wishbone classic bus bundle used for both master-side and slave-side
// connections of wb_arbiter2.
//   adr/dat_w/sel/we/cyc/stb : request fields, driven by the bus master
//   dat_r/ack/err/rty        : response fields, driven by the bus slave
// modport master : the side that issues requests
// modport slave  : the side that answers requests
interface wb_arbiter2_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (output adr, dat_w, sel, we, cyc, stb,
                  input  dat_r, ack, err, rty);
  modport slave  (input  adr, dat_w, sel, we, cyc, stb,
                  output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter in front of the SRAM slave.
// m0 = instruction fetch, m1 = data memory. Grant is registered, the owner's
// request is muxed onto the slave port, responses go back to the owner only.
// A watchdog terminates an access that sees no response for TIMEOUT cycles.
// Ports:
//   clk_bus : bus clock, rising edge
//   rst_bus : asynchronous active-high reset
//   m0, m1  : master-facing ports (slave modport)
//   s       : slave-facing port (master modport)
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 16  // legal 2..255
) (
  input  logic          clk_bus,
  input  logic          rst_bus,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_last,  w_last_nxt;
  logic [7:0] r_wdog;
  logic       w_gnt0, w_gnt1, w_fire, w_wd_clr;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);
  assign w_fire = (w_gnt0 | w_gnt1) & (r_wdog == TO);

  // Next state: cycles are locked while the owner holds cyc; on release the
  // other requester takes over directly, with no IDLE bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0.cyc && m1.cyc) w_state_nxt = r_last ? GNT0 : GNT1;
        else if (m0.cyc)      w_state_nxt = GNT0;
        else if (m1.cyc)      w_state_nxt = GNT1;
      end
      GNT0: if (!m0.cyc) begin
        w_last_nxt  = 1'b0;
        w_state_nxt = m1.cyc ? GNT1 : IDLE;
      end
      GNT1: if (!m1.cyc) begin
        w_last_nxt  = 1'b1;
        w_state_nxt = m0.cyc ? GNT0 : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slave port mux; everything is zero while nobody owns the bus.
  always_comb begin
    s.adr   = '0;
    s.dat_w = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    if (w_gnt0) begin
      s.adr   = m0.adr;
      s.dat_w = m0.dat_w;
      s.sel   = m0.sel;
      s.we    = m0.we;
      s.cyc   = m0.cyc;
      s.stb   = m0.cyc & m0.stb & ~w_fire;
    end else if (w_gnt1) begin
      s.adr   = m1.adr;
      s.dat_w = m1.dat_w;
      s.sel   = m1.sel;
      s.we    = m1.we;
      s.cyc   = m1.cyc;
      s.stb   = m1.cyc & m1.stb & ~w_fire;
    end
  end

  // Responses: read data is broadcast, handshakes reach the owner only.
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = w_gnt0 & s.ack;
  assign m0.rty   = w_gnt0 & s.rty;
  assign m0.err   = w_gnt0 & (s.err | w_fire);
  assign m1.ack   = w_gnt1 & s.ack;
  assign m1.rty   = w_gnt1 & s.rty;
  assign m1.err   = w_gnt1 & (s.err | w_fire);

  // Watchdog restarts on any response, idle strobe, grant change, or after
  // it has fired, so a retried access gets a fresh window.
  assign w_wd_clr = (w_state_nxt != r_state) | s.ack | s.err | s.rty |
                    ~s.stb | w_fire;

  always_ff @(posedge clk_bus or posedge rst_bus) begin
    if (rst_bus) begin
      r_state <= IDLE;
      r_last  <= 1'b1;  // m0 wins the first tie
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      if (w_wd_clr)            r_wdog <= '0;
      else if (r_wdog != 8'hFF) r_wdog <= r_wdog + 8'd1;
    end
  end
endmodule
